// File: rtl/pulse_gen.sv
// pulse_gen: turns one-cycle request strobes into pulses with a programmed
// high width and a guaranteed minimum low gap. Requests that arrive while a
// pulse is running are counted in a saturating pending counter.
module pulse_gen #(
  parameter int WIDTH_BITS = 8,
  parameter int PEND_BITS  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [WIDTH_BITS-1:0] high_cycles,
  input  logic [WIDTH_BITS-1:0] low_cycles,
  output logic                  signal,
  output logic                  busy,
  output logic [PEND_BITS-1:0]  pending,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP
  } state_t;

  state_t                r_state, w_state_next;
  logic [WIDTH_BITS-1:0] r_cnt, w_cnt_next;
  logic                  r_signal, w_signal_next;
  logic [PEND_BITS-1:0]  r_pending, w_pending_next;
  logic                  r_overflow, w_overflow_next;

  logic [WIDTH_BITS-1:0] w_high_load;
  logic [WIDTH_BITS-1:0] w_low_load;
  logic                  w_cnt_zero;
  logic                  w_pend_nz;
  logic                  w_pend_full;
  logic                  w_can_start;
  logic                  w_start;
  logic                  w_consume_q;
  logic                  w_consume_trig;
  logic                  w_accept;
  logic                  w_drop;

  // Phase reload values: a programmed length of 0 behaves as 1, so load 0.
  always_comb begin
    w_high_load = (high_cycles == '0) ? '0 : high_cycles - WIDTH_BITS'(1);
    w_low_load  = (low_cycles  == '0) ? '0 : low_cycles  - WIDTH_BITS'(1);
  end

  // Start decision and request bookkeeping: a start drains the queue first,
  // otherwise it takes the same-cycle trigger directly.
  always_comb begin
    w_cnt_zero     = (r_cnt == '0);
    w_pend_nz      = (r_pending != '0);
    w_pend_full    = (r_pending == '1);
    w_can_start    = (r_state == ST_IDLE) || ((r_state == ST_GAP) && w_cnt_zero);
    w_start        = w_can_start && (w_pend_nz || trigger);
    w_consume_q    = w_start && w_pend_nz;
    w_consume_trig = w_start && !w_pend_nz;
    w_accept       = trigger && !w_consume_trig && (!w_pend_full || w_consume_q);
    w_drop         = trigger && !w_consume_trig && !w_accept;

    w_pending_next = r_pending;
    if (w_accept && !w_consume_q) begin
      w_pending_next = r_pending + PEND_BITS'(1);
    end else if (!w_accept && w_consume_q) begin
      w_pending_next = r_pending - PEND_BITS'(1);
    end
    w_overflow_next = w_drop;
  end

  // Next-state logic for the IDLE/HIGH/GAP sequencer and its phase counter.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_signal_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next  = ST_HIGH;
          w_cnt_next    = w_high_load;
          w_signal_next = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_cnt_zero) begin
          w_state_next  = ST_GAP;
          w_cnt_next    = w_low_load;
          w_signal_next = 1'b0;
        end else begin
          w_cnt_next    = r_cnt - WIDTH_BITS'(1);
          w_signal_next = 1'b1;
        end
      end
      ST_GAP: begin
        if (!w_cnt_zero) begin
          w_cnt_next = r_cnt - WIDTH_BITS'(1);
        end else if (w_start) begin
          w_state_next  = ST_HIGH;
          w_cnt_next    = w_high_load;
          w_signal_next = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State register; reset discards queued requests and ignores trigger.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_signal   <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_signal   <= w_signal_next;
      r_pending  <= w_pending_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign signal   = r_signal;
  assign busy     = (r_state != ST_IDLE);
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_gen.sv
// Testbench for pulse_gen: a timestamp-based reference model predicts each
// cycle's outputs into a queue; a monitor pops and compares them.
module tb_pulse_gen;

  localparam int WB   = 8;
  localparam int PB   = 2;
  localparam int QMAX = (1 << PB) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          trigger;
  logic [WB-1:0] high_cycles;
  logic [WB-1:0] low_cycles;
  logic          signal;
  logic          busy;
  logic [PB-1:0] pending;
  logic          overflow;

  pulse_gen #(.WIDTH_BITS(WB), .PEND_BITS(PB)) dut (
    .clock       (clock),
    .reset       (reset),
    .trigger     (trigger),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .signal      (signal),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sig;
    int bsy;
    int pend;
    int ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int rises  = 0;
  int ovfs   = 0;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endfunction

  function automatic int eff(logic [WB-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  // Reference model: tracks when the latest pulse rose and its lengths, and
  // derives every output from cycle arithmetic on those timestamps.
  int m_edge  = 0;
  bit m_valid = 0;
  bit m_have  = 0;
  int m_rise  = 0;
  int m_h     = 1;
  int m_l     = 1;
  int m_q     = 0;
  bit m_ovf   = 0;

  always @(posedge clock) begin : model
    int   k;
    bit   can, start, from_q, direct;
    exp_t x;
    m_edge++;
    k = m_edge - 1;
    if (reset) begin
      m_valid = 1;
      m_have  = 0;
      m_q     = 0;
      m_ovf   = 0;
    end else if (m_valid) begin
      if (m_have && k == m_rise + m_h - 1) m_l = eff(low_cycles);
      can    = !m_have || (k >= m_rise + m_h + m_l - 1);
      start  = can && (m_q > 0 || trigger);
      from_q = start && (m_q > 0);
      direct = start && (m_q == 0);
      m_ovf  = 0;
      if (trigger && !direct) begin
        if (m_q < QMAX || from_q) m_q++;
        else m_ovf = 1;
      end
      if (from_q) m_q--;
      if (start) begin
        m_have = 1;
        m_rise = m_edge;
        m_h    = eff(high_cycles);
        m_l    = 1;
      end
    end
    if (m_valid) begin
      x.sig  = (m_have && m_edge >= m_rise && m_edge < m_rise + m_h) ? 1 : 0;
      x.bsy  = (m_have && m_edge < m_rise + m_h + m_l) ? 1 : 0;
      x.pend = m_q;
      x.ovf  = m_ovf ? 1 : 0;
      exp_q.push_back(x);
    end
  end

  // Monitor: compares the DUT against the oldest prediction each cycle.
  logic prev_sig = 1'b0;
  always @(posedge clock) begin : monitor
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("signal",   int'(signal),   x.sig);
      check("busy",     int'(busy),     x.bsy);
      check("pending",  int'(pending),  x.pend);
      check("overflow", int'(overflow), x.ovf);
    end
    if (signal && !prev_sig) rises++;
    if (overflow) ovfs++;
    prev_sig = signal;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  int r0, o0;

  initial begin
    reset       = 1'b1;
    trigger     = 1'b0;
    high_cycles = 8'd3;
    low_cycles  = 8'd2;
    tick(1);
    trigger = 1'b1;
    tick(2);
    trigger = 1'b0;
    reset   = 1'b0;
    r0 = rises;
    tick(10);
    check("no_pulse_after_reset_trigger", rises - r0, 0);

    // Single pulse, H=3 L=2.
    r0 = rises;
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
    tick(10);
    check("single_pulse_rises", rises - r0, 1);

    // Three back-to-back requests, H=2 L=1.
    high_cycles = 8'd2;
    low_cycles  = 8'd1;
    r0 = rises;
    trigger = 1'b1;
    tick(3);
    trigger = 1'b0;
    tick(15);
    check("three_pulse_rises", rises - r0, 3);

    // Queue saturation, H=8 L=8, six requests.
    high_cycles = 8'd8;
    low_cycles  = 8'd8;
    r0 = rises;
    o0 = ovfs;
    trigger = 1'b1;
    tick(6);
    trigger = 1'b0;
    tick(70);
    check("saturate_rises", rises - r0, 4);
    check("saturate_overflows", ovfs - o0, 2);

    // Zero lengths with continuous trigger, then widen the high phase.
    high_cycles = 8'd0;
    low_cycles  = 8'd0;
    trigger = 1'b1;
    tick(12);
    high_cycles = 8'd5;
    tick(1);
    trigger = 1'b0;
    tick(40);

    // Reset in the middle of a long pulse with two requests queued.
    high_cycles = 8'd10;
    low_cycles  = 8'd4;
    trigger = 1'b1;
    tick(3);
    trigger = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    r0 = rises;
    tick(30);
    check("no_pulse_after_mid_reset", rises - r0, 0);

    // Randomized traffic with occasional resets and length changes.
    for (int i = 0; i < 3000; i++) begin
      trigger = ($urandom_range(99) < 30);
      reset   = ($urandom_range(199) == 0);
      if ($urandom_range(9) == 0) begin
        high_cycles = WB'($urandom_range(6));
        low_cycles  = WB'($urandom_range(6));
      end
      tick(1);
    end
    trigger = 1'b0;
    reset   = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
